redmule_mx_slot_queue: RTL and testbench
========================================

# redmule_mx_slot_queue

Multi-channel, parametrised slot queue for the MX datapath, sitting between the streamer and the MX arbiter. Each channel splits wide streamer beats into fixed-width mantissa slots and pairs them with per-block shared exponents. Each exponent may be reused across a run-time number of slots. Configuration is latched only while the block is idle.

## Interface
Parameters:
- NUM_CH, 2, number of independent channels (X, W, ...)
- SLOT_W, 256, mantissa slot width in bits
- SLOTS_PER_BEAT, 2, slots carried by one input beat in split mode; BEAT_W = SLOT_W*SLOTS_PER_BEAT
- EXP_W, 32, exponent word width
- SLOT_DEPTH, 4, mantissa slots per channel; multiple of SLOTS_PER_BEAT and >= 2*SLOTS_PER_BEAT (elaboration $fatal otherwise)
- EXP_DEPTH, 6, exponent entries per channel
- MAX_REUSE, 4, maximum slots sharing one exponent; RW = $clog2(MAX_REUSE+1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- clear_i  in  1  synchronous flush of all queues and counters
- split_en_i  in  1  1: split beat into SLOTS_PER_BEAT slots; 0: pass-through, lower SLOT_W bits only, one slot per beat
- reuse_i  in  RW  slot pops per exponent; 0 is treated as 1; values above MAX_REUSE are clamped to MAX_REUSE
- beat_valid_i / beat_ready_o  in/out  NUM_CH  per-channel beat handshake
- beat_data_i  in  NUM_CH x BEAT_W  beat payload, slot k = bits [k*SLOT_W +: SLOT_W]
- exp_valid_i / exp_ready_o  in/out  NUM_CH  per-channel exponent handshake
- exp_data_i  in  NUM_CH x EXP_W  exponent payload
- slot_valid_o / slot_ready_i  out/in  NUM_CH  paired slot output handshake
- slot_data_o  out  NUM_CH x SLOT_W  head mantissa slot; '0 when no data
- slot_exp_o  out  NUM_CH x EXP_W  head exponent; '0 when no exponent
- slot_last_o  out  NUM_CH  current pop retires the head exponent
- data_count_o  out  NUM_CH x $clog2(SLOT_DEPTH+1)  mantissa occupancy
- exp_count_o  out  NUM_CH x $clog2(EXP_DEPTH+1)  exponent occupancy

## Operation
- Config register {split, reuse_eff} loads from inputs in every cycle in which all channels have data_count = 0, exp_count = 0 and reuse counter = 0. Otherwise it holds. After reset: split = 0, reuse_eff = 1.
- spb_eff = SLOTS_PER_BEAT when split, else 1.
- beat_ready_o[c] = data_count_q <= SLOT_DEPTH - spb_eff. It depends on registered state only.
- A beat push writes spb_eff slots at tail, tail, tail+1, ... with modulo-SLOT_DEPTH wrap, and adds spb_eff to the count.
- exp_ready_o[c] = (exp_count_q < EXP_DEPTH) and (exp_count_q <= data_count_q). An exponent may run at most one entry ahead of stored slots.
- slot_valid_o[c] = data_count_q != 0 and exp_count_q != 0.
- A pop occurs when slot_valid_o and slot_ready_i are both high. A pop removes the head slot and increments the per-channel reuse counter.
- slot_last_o = (reuse_cnt_q == reuse_eff-1). On a pop with slot_last_o high, the head exponent is also removed and the reuse counter returns to 0.
- Push and pop in the same cycle are both performed. Count update is +spb_eff-1 (data) and +1-last (exponent).
- Channels are fully independent. A stall on one channel never affects another.
- Priority: rst_i > clear_i > push/pop. clear_i zeroes pointers, counts and reuse counters, and discards same-cycle pushes and pops. Memory contents are not cleared.
- Ready is not asserted when full. Valid is not asserted when empty. Pointers wrap at depth-1 to 0. Depths need not be powers of two.

## Timing
- Reset values: beat_ready_o = all 1 (count 0 <= SLOT_DEPTH-1), exp_ready_o = all 1, slot_valid_o = 0, slot_data_o = 0, slot_exp_o = 0, slot_last_o = 1 (reuse_eff = 1), counts = 0.
- Latency: a pushed slot or exponent is visible at the output the cycle after its push (1 cycle). No combinational path runs from inputs to outputs except slot_ready_i to nothing. All outputs are registered-state functions.
- Reset asserted mid-transfer empties the queues on the next edge. In-flight beats are dropped; upstream must re-send.

## Structure
- redmule_pkg holds typedef mx_slot_cfg_t {logic split; logic [RW-1:0] reuse;} and a function for modulo-depth pointer increment.
- One sub-module, redmule_mx_chan_queue, is instantiated NUM_CH times. It owns both FIFOs, the reuse counter and the handshakes. The top owns the config register and the idle detection.

## Test plan
- Split mode, reuse 1: push beat {B,A} on channel 0 and exponents E0 and E1, then pop twice. Required: (A,E0,last=1), then (B,E1,last=1). data_count sequence 2→1→0.
- Reuse 2, split: push 2 beats (4 slots) and 2 exponents, then hold slot_ready_i high. Required: slot_last_o = 0,1,0,1, exponents E0,E0,E1,E1, exp_count 2→2→1→1→0.
- Full and wrap: SLOT_DEPTH=4, split mode, push 2 beats with no pops. Required: beat_ready_o=0 at count 4. Pop 2 and push 1. Required: tail wraps to 0 and data order is preserved over 3 fills.
- Exponent throttle: with no beats pushed, offer 3 exponents. Required: 1 accepted (0<=0), then exp_ready_o=0 until a beat arrives.
- Simultaneous push and pop at count 2, split: required count 3, and beat_ready_o then deasserts.
- Config change while data_count=1: split_en_i toggles. Required: no effect until the queue drains, then the new mode applies on the next push. Also assert clear_i together with a push: required all counts 0 and no slot accepted.

Source files
------------

// File: rtl/redmule_pkg.sv
// Shared types and helpers for the MX slot queue: the config word and the
// modulo-depth pointer increment used by the per-channel FIFOs.
package redmule_pkg;

  localparam int MX_MAX_REUSE = 4;
  localparam int MX_RW        = $clog2(MX_MAX_REUSE + 1);

  typedef struct packed {
    logic             split;
    logic [MX_RW-1:0] reuse;
  } mx_slot_cfg_t;

  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/redmule_mx_chan_queue.sv
// One MX channel: mantissa slot FIFO, shared-exponent FIFO, reuse counter
// and the three handshakes. All outputs are functions of registered state.
module redmule_mx_chan_queue
  import redmule_pkg::*;
#(
  parameter int SLOT_W     = 256,
  parameter int SPB        = 2,
  parameter int EXP_W      = 32,
  parameter int SLOT_DEPTH = 4,
  parameter int EXP_DEPTH  = 6,
  parameter int DCW        = $clog2(SLOT_DEPTH + 1),
  parameter int ECW        = $clog2(EXP_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  split,
  input  logic [MX_RW-1:0]      reuse,
  input  logic                  beat_valid,
  output logic                  beat_ready,
  input  logic [SPB*SLOT_W-1:0] beat_data,
  input  logic                  exp_valid,
  output logic                  exp_ready,
  input  logic [EXP_W-1:0]      exp_data,
  output logic                  slot_valid,
  input  logic                  slot_ready,
  output logic [SLOT_W-1:0]     slot_data,
  output logic [EXP_W-1:0]      slot_exp,
  output logic                  slot_last,
  output logic [DCW-1:0]        data_count,
  output logic [ECW-1:0]        exp_count,
  output logic                  idle
);

  localparam int SPW = $clog2(SLOT_DEPTH);
  localparam int EPW = (EXP_DEPTH > 1) ? $clog2(EXP_DEPTH) : 1;

  logic [SLOT_W-1:0] d_mem [SLOT_DEPTH];
  logic [EXP_W-1:0]  e_mem [EXP_DEPTH];

  logic [SPW-1:0]   d_head_q, d_tail_q;
  logic [EPW-1:0]   e_head_q, e_tail_q;
  logic [DCW-1:0]   d_cnt_q;
  logic [ECW-1:0]   e_cnt_q;
  logic [MX_RW-1:0] rcnt_q;

  logic [DCW-1:0] spb_eff;
  logic [SPW-1:0] wr_idx [SPB+1];
  logic           push_b, push_e, pop, pop_e;

  // Slot k of a beat lands at tail+k; tail+k never reaches 2*SLOT_DEPTH.
  always_comb begin
    for (int k = 0; k <= SPB; k++) begin
      if (int'(d_tail_q) + k >= SLOT_DEPTH) wr_idx[k] = SPW'(int'(d_tail_q) + k - SLOT_DEPTH);
      else                                  wr_idx[k] = SPW'(int'(d_tail_q) + k);
    end
  end

  assign spb_eff    = split ? DCW'(SPB) : DCW'(1);
  assign beat_ready = int'(d_cnt_q) <= SLOT_DEPTH - int'(spb_eff);
  assign exp_ready  = (int'(e_cnt_q) < EXP_DEPTH) && (int'(e_cnt_q) <= int'(d_cnt_q));
  assign slot_valid = (d_cnt_q != '0) && (e_cnt_q != '0);
  assign slot_last  = (rcnt_q == reuse - 1'b1);
  assign slot_data  = (d_cnt_q != '0) ? d_mem[d_head_q] : '0;
  assign slot_exp   = (e_cnt_q != '0) ? e_mem[e_head_q] : '0;
  assign data_count = d_cnt_q;
  assign exp_count  = e_cnt_q;
  assign idle       = (d_cnt_q == '0) && (e_cnt_q == '0) && (rcnt_q == '0);

  assign push_b = beat_valid && beat_ready;
  assign push_e = exp_valid && exp_ready;
  assign pop    = slot_valid && slot_ready;
  assign pop_e  = pop && slot_last;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      d_head_q <= '0;
      d_tail_q <= '0;
      e_head_q <= '0;
      e_tail_q <= '0;
      d_cnt_q  <= '0;
      e_cnt_q  <= '0;
      rcnt_q   <= '0;
    end else begin
      if (push_b) d_tail_q <= split ? wr_idx[SPB] : wr_idx[1];
      if (pop)    d_head_q <= SPW'(ptr_inc(int'(d_head_q), SLOT_DEPTH));
      if (push_e) e_tail_q <= EPW'(ptr_inc(int'(e_tail_q), EXP_DEPTH));
      if (pop_e)  e_head_q <= EPW'(ptr_inc(int'(e_head_q), EXP_DEPTH));
      if (pop)    rcnt_q   <= slot_last ? '0 : rcnt_q + 1'b1;
      d_cnt_q <= d_cnt_q + (push_b ? spb_eff : '0) - DCW'(pop);
      e_cnt_q <= e_cnt_q + ECW'(push_e) - ECW'(pop_e);
    end
  end

  // Storage is never reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_b && !rst && !clear) begin
      for (int k = 0; k < SPB; k++) begin
        if (k == 0 || split) d_mem[wr_idx[k]] <= beat_data[k*SLOT_W +: SLOT_W];
      end
    end
    if (push_e && !rst && !clear) e_mem[e_tail_q] <= exp_data;
  end

endmodule

// File: rtl/redmule_mx_slot_queue.sv
// MX slot queue top: NUM_CH independent channel queues sharing one config
// register {split, reuse} that only reloads while every channel is idle.
module redmule_mx_slot_queue
  import redmule_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int SLOT_W         = 256,
  parameter int SLOTS_PER_BEAT = 2,
  parameter int EXP_W          = 32,
  parameter int SLOT_DEPTH     = 4,
  parameter int EXP_DEPTH      = 6,
  parameter int MAX_REUSE      = 4,
  localparam int BEAT_W = SLOT_W * SLOTS_PER_BEAT,
  localparam int RW     = $clog2(MAX_REUSE + 1),
  localparam int DCW    = $clog2(SLOT_DEPTH + 1),
  localparam int ECW    = $clog2(EXP_DEPTH + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    split_en_i,
  input  logic [RW-1:0]           reuse_i,
  input  logic [NUM_CH-1:0]       beat_valid_i,
  output logic [NUM_CH-1:0]       beat_ready_o,
  input  logic [NUM_CH*BEAT_W-1:0] beat_data_i,
  input  logic [NUM_CH-1:0]       exp_valid_i,
  output logic [NUM_CH-1:0]       exp_ready_o,
  input  logic [NUM_CH*EXP_W-1:0] exp_data_i,
  output logic [NUM_CH-1:0]       slot_valid_o,
  input  logic [NUM_CH-1:0]       slot_ready_i,
  output logic [NUM_CH*SLOT_W-1:0] slot_data_o,
  output logic [NUM_CH*EXP_W-1:0] slot_exp_o,
  output logic [NUM_CH-1:0]       slot_last_o,
  output logic [NUM_CH*DCW-1:0]   data_count_o,
  output logic [NUM_CH*ECW-1:0]   exp_count_o
);

  if ((SLOT_DEPTH % SLOTS_PER_BEAT) != 0 || SLOT_DEPTH < 2 * SLOTS_PER_BEAT) begin : g_depth_chk
    $fatal(1, "SLOT_DEPTH must be a multiple of SLOTS_PER_BEAT and at least twice it");
  end
  if (RW > MX_RW) begin : g_reuse_chk
    $fatal(1, "MAX_REUSE exceeds the reuse width of mx_slot_cfg_t");
  end

  mx_slot_cfg_t      cfg_q;
  logic [MX_RW-1:0]  reuse_ext, reuse_eff;
  logic [NUM_CH-1:0] ch_idle;

  assign reuse_ext = MX_RW'(reuse_i);

  always_comb begin
    reuse_eff = reuse_ext;
    if (reuse_ext == '0)                      reuse_eff = MX_RW'(1);
    else if (int'(reuse_ext) > MAX_REUSE)     reuse_eff = MX_RW'(MAX_REUSE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_q.split <= 1'b0;
      cfg_q.reuse <= MX_RW'(1);
    end else if (&ch_idle) begin
      cfg_q.split <= split_en_i;
      cfg_q.reuse <= reuse_eff;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    redmule_mx_chan_queue #(
      .SLOT_W     (SLOT_W),
      .SPB        (SLOTS_PER_BEAT),
      .EXP_W      (EXP_W),
      .SLOT_DEPTH (SLOT_DEPTH),
      .EXP_DEPTH  (EXP_DEPTH),
      .DCW        (DCW),
      .ECW        (ECW)
    ) u_chan (
      .clk        (clk_i),
      .rst        (rst_i),
      .clear      (clear_i),
      .split      (cfg_q.split),
      .reuse      (cfg_q.reuse),
      .beat_valid (beat_valid_i[c]),
      .beat_ready (beat_ready_o[c]),
      .beat_data  (beat_data_i[c*BEAT_W +: BEAT_W]),
      .exp_valid  (exp_valid_i[c]),
      .exp_ready  (exp_ready_o[c]),
      .exp_data   (exp_data_i[c*EXP_W +: EXP_W]),
      .slot_valid (slot_valid_o[c]),
      .slot_ready (slot_ready_i[c]),
      .slot_data  (slot_data_o[c*SLOT_W +: SLOT_W]),
      .slot_exp   (slot_exp_o[c*EXP_W +: EXP_W]),
      .slot_last  (slot_last_o[c]),
      .data_count (data_count_o[c*DCW +: DCW]),
      .exp_count  (exp_count_o[c*ECW +: ECW]),
      .idle       (ch_idle[c])
    );
  end

endmodule

// File: tb/tb_redmule_mx_slot_queue.sv
// Directed bench for redmule_mx_slot_queue: channel 0 is tracked by a
// scoreboard of expected slots/exponents, channel 1 is checked directly.
module tb_redmule_mx_slot_queue;

  localparam int NUM_CH = 2, SLOT_W = 256, SPB = 2, EXP_W = 32;
  localparam int SLOT_DEPTH = 4, EXP_DEPTH = 6, MAX_REUSE = 4;
  localparam int BEAT_W = SLOT_W * SPB, RW = 3, DCW = 3, ECW = 3;

  logic clk = 1'b0;
  logic rst_i, clear_i, split_en_i;
  logic [RW-1:0] reuse_i;
  logic [NUM_CH-1:0] beat_valid_i, beat_ready_o, exp_valid_i, exp_ready_o;
  logic [NUM_CH-1:0] slot_valid_o, slot_ready_i, slot_last_o;
  logic [NUM_CH*BEAT_W-1:0] beat_data_i;
  logic [NUM_CH*EXP_W-1:0]  exp_data_i, slot_exp_o;
  logic [NUM_CH*SLOT_W-1:0] slot_data_o;
  logic [NUM_CH*DCW-1:0]    data_count_o;
  logic [NUM_CH*ECW-1:0]    exp_count_o;

  always #5 clk = ~clk;

  redmule_mx_slot_queue #(
    .NUM_CH(NUM_CH), .SLOT_W(SLOT_W), .SLOTS_PER_BEAT(SPB), .EXP_W(EXP_W),
    .SLOT_DEPTH(SLOT_DEPTH), .EXP_DEPTH(EXP_DEPTH), .MAX_REUSE(MAX_REUSE)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .split_en_i(split_en_i),
    .reuse_i(reuse_i), .beat_valid_i(beat_valid_i), .beat_ready_o(beat_ready_o),
    .beat_data_i(beat_data_i), .exp_valid_i(exp_valid_i), .exp_ready_o(exp_ready_o),
    .exp_data_i(exp_data_i), .slot_valid_o(slot_valid_o), .slot_ready_i(slot_ready_i),
    .slot_data_o(slot_data_o), .slot_exp_o(slot_exp_o), .slot_last_o(slot_last_o),
    .data_count_o(data_count_o), .exp_count_o(exp_count_o)
  );

  int checks = 0;
  int failures = 0;

  logic [SLOT_W-1:0] mq[$];
  logic [EXP_W-1:0]  eq[$];
  int rc = 0;
  int m_reuse = 1;
  logic m_split = 1'b0;
  logic [EXP_W-1:0] e_seq = 32'he000_0000;

  task automatic chk(input string tag, input logic [SLOT_W-1:0] obs, input logic [SLOT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SLOT_W-1:0] rnd_slot();
    logic [SLOT_W-1:0] v;
    for (int i = 0; i < SLOT_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One clock on channel 0: check outputs against the scoreboard, clock,
  // then apply the accepted transfers to the scoreboard and check counts.
  task automatic cyc(input logic bv, input logic ev, input logic rdy, input logic clr);
    logic [BEAT_W-1:0] bd;
    int spb;
    logic idle, pb, pe, pp, lst;
    bd = {rnd_slot(), rnd_slot()};
    beat_valid_i[0] = bv;
    beat_data_i[BEAT_W-1:0] = bd;
    exp_valid_i[0] = ev;
    exp_data_i[EXP_W-1:0] = e_seq;
    slot_ready_i[0] = rdy;
    clear_i = clr;
    #1;
    spb  = m_split ? SPB : 1;
    idle = (mq.size() == 0) && (eq.size() == 0) && (rc == 0);
    pb   = bv && (mq.size() <= SLOT_DEPTH - spb);
    pe   = ev && (eq.size() < EXP_DEPTH) && (eq.size() <= mq.size());
    pp   = rdy && (mq.size() != 0) && (eq.size() != 0);
    lst  = (rc == m_reuse - 1);
    chk("beat_ready", beat_ready_o[0], mq.size() <= SLOT_DEPTH - spb);
    chk("exp_ready", exp_ready_o[0], (eq.size() < EXP_DEPTH) && (eq.size() <= mq.size()));
    chk("slot_valid", slot_valid_o[0], (mq.size() != 0) && (eq.size() != 0));
    chk("slot_last", slot_last_o[0], lst);
    chk("slot_data", slot_data_o[SLOT_W-1:0], (mq.size() != 0) ? mq[0] : '0);
    chk("slot_exp", slot_exp_o[EXP_W-1:0], (eq.size() != 0) ? eq[0] : '0);
    @(posedge clk); #1;
    if (clr) begin
      mq.delete(); eq.delete(); rc = 0;
    end else begin
      if (pp) begin
        void'(mq.pop_front());
        if (lst) begin void'(eq.pop_front()); rc = 0; end
        else rc++;
      end
      if (pb) begin
        mq.push_back(bd[SLOT_W-1:0]);
        if (m_split) mq.push_back(bd[SLOT_W +: SLOT_W]);
      end
      if (pe) begin eq.push_back(e_seq); e_seq++; end
    end
    if (idle) begin
      m_split = split_en_i;
      m_reuse = (reuse_i == 0) ? 1 : (int'(reuse_i) > MAX_REUSE) ? MAX_REUSE : int'(reuse_i);
    end
    chk("data_count", data_count_o[DCW-1:0], mq.size());
    chk("exp_count", exp_count_o[ECW-1:0], eq.size());
  endtask

  // Reuse-1 drain: feed an exponent per stored slot, pop until empty.
  task automatic drain();
    for (int i = 0; i < 40 && (mq.size() != 0 || eq.size() != 0); i++)
      cyc(1'b0, eq.size() < mq.size(), 1'b1, 1'b0);
    chk("drain_empty", (mq.size() == 0) && (eq.size() == 0), 1'b1);
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; split_en_i = 1'b1; reuse_i = '0;
    beat_valid_i = '0; exp_valid_i = '0; slot_ready_i = '0;
    beat_data_i = '0; exp_data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_beat_ready", beat_ready_o, 2'b11);
    chk("rst_exp_ready", exp_ready_o, 2'b11);
    chk("rst_slot_valid", slot_valid_o, 2'b00);
    chk("rst_slot_data", slot_data_o[SLOT_W-1:0], '0);
    chk("rst_slot_exp", slot_exp_o, '0);
    chk("rst_slot_last", slot_last_o, 2'b11);
    chk("rst_counts", {data_count_o, exp_count_o}, '0);
    rst_i = 1'b0;

    // split, reuse_i=0 (acts as 1): beat {B,A}, E0, E1, two pops
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("t1_count2", data_count_o[DCW-1:0], 3'd2);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    chk("t1_count1", data_count_o[DCW-1:0], 3'd1);
    cyc(0, 0, 1, 0);
    chk("t1_count0", data_count_o[DCW-1:0], 3'd0);

    // reuse 2: 4 slots, 2 exponents, last pattern 0,1,0,1
    reuse_i = 3'd2;
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("t2_last0", slot_last_o[0], 1'b0);
    repeat (4) cyc(0, 0, 1, 0);
    chk("t2_empty", {data_count_o[DCW-1:0], exp_count_o[ECW-1:0]}, '0);

    // full and wrap, reuse 1
    reuse_i = 3'd1;
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("t3_full_ready", beat_ready_o[0], 1'b0);
    cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    chk("t3_refill", data_count_o[DCW-1:0], 3'd4);
    drain();
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    drain();

    // exponent throttle with no beats stored
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("t4_exp_blocked", exp_ready_o[0], 1'b0);
    chk("t4_exp_one", exp_count_o[ECW-1:0], 3'd1);
    cyc(1, 1, 0, 0);
    chk("t4_exp_reopen", exp_ready_o[0], 1'b1);
    drain();

    // simultaneous push and pop at count 2
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 0, 1, 0);
    chk("t5_count3", data_count_o[DCW-1:0], 3'd3);
    chk("t5_ready_low", beat_ready_o[0], 1'b0);
    drain();

    // config change while not idle
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    split_en_i = 1'b0;
    cyc(1, 0, 0, 0);
    chk("t6_still_split", data_count_o[DCW-1:0], 3'd3);
    drain();
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("t6_passthru", data_count_o[DCW-1:0], 3'd1);
    drain();

    // clear with a same-cycle push, then clear with push+pop over data
    cyc(1, 1, 0, 1);
    chk("t7_clear_push", {data_count_o[DCW-1:0], exp_count_o[ECW-1:0]}, '0);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 1, 1);
    chk("t7_clear_all", {data_count_o, exp_count_o}, '0);
    chk("t7_no_valid", slot_valid_o, 2'b00);

    // channel independence: ch0 stalled with one slot, ch1 transfers
    cyc(1, 0, 0, 0);
    beat_valid_i[1] = 1'b1;
    beat_data_i[BEAT_W +: BEAT_W] = {256'hdead, 256'h1234_5678_9abc};
    cyc(0, 0, 0, 0);
    beat_valid_i[1] = 1'b0;
    exp_valid_i[1] = 1'b1;
    exp_data_i[EXP_W +: EXP_W] = 32'h0000_c1e0;
    cyc(0, 0, 0, 0);
    exp_valid_i[1] = 1'b0;
    chk("ch1_valid", slot_valid_o[1], 1'b1);
    chk("ch1_data", slot_data_o[SLOT_W +: SLOT_W], 256'h1234_5678_9abc);
    chk("ch1_exp", slot_exp_o[EXP_W +: EXP_W], 32'h0000_c1e0);
    chk("ch1_last", slot_last_o[1], 1'b1);
    slot_ready_i[1] = 1'b1;
    cyc(0, 0, 0, 0);
    slot_ready_i[1] = 1'b0;
    chk("ch1_empty", {data_count_o[DCW +: DCW], exp_count_o[ECW +: ECW]}, '0);
    chk("ch0_held", data_count_o[DCW-1:0], 3'd1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
